stream_rx: RTL and testbench

STREAM_RX -- requirements
Module: stream_rx

---
 rtl/stream_rx_pkg.sv | 11 +
 rtl/stream_rx_uart_rx.sv | 99 +++++++++
 rtl/stream_rx.sv | 89 ++++++++
 tb/tb_stream_rx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/stream_rx_pkg.sv
// Shared constants and helpers for the line-oriented UART receiver.
package stream_rx_pkg;

  localparam int LINE_DEPTH = 8;

  // Clocks per serial bit, truncated toward zero.
  function automatic int bit_ticks(input int clock_hz, input int baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/stream_rx_uart_rx.sv
// 8N1 serial deserializer: 2-flop synchronizer, bit timer and start/data/stop FSM.
module uart_rx
  import stream_rx_pkg::*;
#(
  parameter int CLOCK_HZ = 10_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Rx_i,
  output logic [7:0] Data_o,
  output logic       Done_o,
  output logic       FrameErr_o
);

  localparam int TICKS = bit_ticks(CLOCK_HZ, BAUD);
  localparam int CW    = $clog2(TICKS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(TICKS / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_e;

  rx_state_e      state_q;
  logic           sync1_q, sync2_q, prev_q;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     bit_q;
  logic [7:0]     shift_q;
  logic           fall_d;

  assign fall_d = prev_q && !sync2_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      Data_o     <= '0;
      Done_o     <= 1'b0;
      FrameErr_o <= 1'b0;
    end else begin
      sync1_q    <= Rx_i;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      Done_o     <= 1'b0;
      FrameErr_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (fall_d) state_q <= S_START;
        end
        // Re-check the line half a bit in; a high level means the edge was a glitch.
        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= sync2_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            if (bit_q == 3'd7) state_q <= S_STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            if (sync2_q) begin
              Done_o <= 1'b1;
              Data_o <= shift_q;
            end else begin
              FrameErr_o <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/stream_rx.sv
// Line receiver: collects UART bytes into an 8-byte buffer until a terminator or full line.
module stream_rx
  import stream_rx_pkg::*;
#(
  parameter int         CLOCK_HZ   = 10_000_000,
  parameter int         BAUD       = 115_200,
  parameter logic [7:0] TERMINATOR = 8'h0D
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Rx_i,
  input  logic       Ack_i,
  input  logic [2:0] Addr_i,
  output logic [7:0] Data_o,
  output logic [3:0] Length_o,
  output logic       Ready_o,
  output logic       Overrun_o,
  output logic       FrameErr_o
);

  typedef enum logic {
    L_COLLECT = 1'b0,
    L_READY   = 1'b1
  } line_state_e;

  line_state_e line_state_q;
  logic [3:0]  len_q;
  logic        overrun_q;
  logic [7:0]  buf_q [LINE_DEPTH];
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        wr_en_d;

  uart_rx #(
    .CLOCK_HZ(CLOCK_HZ),
    .BAUD    (BAUD)
  ) u_uart_rx (
    .Clock     (Clock),
    .Reset     (Reset),
    .Rx_i      (Rx_i),
    .Data_o    (rx_data),
    .Done_o    (rx_done),
    .FrameErr_o(FrameErr_o)
  );

  // Handshake: rx_done is a one-cycle valid with no back-pressure; the line is
  // offered via Ready_o and released by a one-cycle Ack_i, which is only honoured in READY.
  assign wr_en_d = (line_state_q == L_COLLECT) && rx_done && (rx_data != TERMINATOR);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      line_state_q <= L_COLLECT;
      len_q        <= '0;
      overrun_q    <= 1'b0;
    end else begin
      case (line_state_q)
        L_COLLECT: begin
          if (rx_done) begin
            if (rx_data == TERMINATOR) begin
              line_state_q <= L_READY;
            end else begin
              len_q <= len_q + 4'd1;
              if (len_q == 4'(LINE_DEPTH - 1)) line_state_q <= L_READY;
            end
          end
        end
        L_READY: begin
          if (rx_done) overrun_q <= 1'b1;
          if (Ack_i) begin
            line_state_q <= L_COLLECT;
            len_q        <= '0;
          end
        end
        default: line_state_q <= L_COLLECT;
      endcase
    end
  end

  // Storage is deliberately left unreset; only Length_o says which entries are valid.
  always_ff @(posedge Clock) begin
    if (wr_en_d) buf_q[len_q[2:0]] <= rx_data;
  end

  assign Data_o    = buf_q[Addr_i];
  assign Length_o  = len_q;
  assign Ready_o   = (line_state_q == L_READY);
  assign Overrun_o = overrun_q;

endmodule

// File: tb/tb_stream_rx.sv
// Directed bench for stream_rx: drives 8N1 frames at the default baud and checks line results.
`timescale 1ns/1ps
module tb_stream_rx;

  localparam int TICKS = 86;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       ack   = 1'b0;
  logic [2:0] addr  = '0;
  logic [7:0] data;
  logic [3:0] length;
  logic       ready;
  logic       overrun;
  logic       frame_err;

  int         checks = 0;
  int         errors = 0;
  int         fe_cnt = 0;
  logic [7:0] exp_q[$];

  stream_rx dut (
    .Clock     (clk),
    .Reset     (rst_n),
    .Rx_i      (rx),
    .Ack_i     (ack),
    .Addr_i    (addr),
    .Data_o    (data),
    .Length_o  (length),
    .Ready_o   (ready),
    .Overrun_o (overrun),
    .FrameErr_o(frame_err)
  );

  // Clock / reset
  always #50 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && frame_err) fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_cycles(TICKS);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
    rx = 1'b1;
    wait_cycles(10);
  endtask

  task automatic pulse_ack();
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    wait_cycles(2);
  endtask

  // Scoreboard: drain exp_q against the buffer, index by index.
  task automatic check_line(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      addr = 3'(i);
      #1;
      check(tag, data, exp_q.pop_front());
    end
  endtask

  initial begin
    logic [7:0] z;
    z = 8'h5A;

    rst_n = 1'b0;
    wait_cycles(5);
    check("rst_length",  length,    0);
    check("rst_ready",   ready,     0);
    check("rst_overrun", overrun,   0);
    check("rst_frameerr", frame_err, 0);
    rst_n = 1'b1;
    wait_cycles(5);

    // Empty line
    send_byte(8'h0D, 1'b1);
    check("empty_ready",  ready,  1);
    check("empty_length", length, 0);
    pulse_ack();
    check("empty_ack_ready", ready, 0);

    // "Hi" + CR
    send_byte(8'h48, 1'b1);
    send_byte(8'h69, 1'b1);
    check("hi_pre_ready",  ready,  0);
    check("hi_pre_length", length, 2);
    send_byte(8'h0D, 1'b1);
    check("hi_ready",  ready,  1);
    check("hi_length", length, 2);
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h69);
    check_line("hi_data");
    pulse_ack();
    check("hi_ack_length", length, 0);

    // Framing error
    send_byte(8'h55, 1'b0);
    wait_cycles(20);
    check("fe_pulses", fe_cnt, 1);
    check("fe_length", length, 0);
    check("fe_ready",  ready,  0);

    // Glitch on the line
    rx = 1'b0;
    wait_cycles(20);
    rx = 1'b1;
    wait_cycles(200);
    check("glitch_length", length, 0);
    check("glitch_fe",     fe_cnt, 1);
    send_byte(8'h41, 1'b1);
    send_byte(8'h0D, 1'b1);
    check("glitch_ready",  ready,  1);
    check("glitch_length2", length, 1);
    exp_q.push_back(8'h41);
    check_line("glitch_data");
    pulse_ack();

    // Full line then overrun
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(8'h41 + i), 1'b1);
      exp_q.push_back(8'(8'h41 + i));
    end
    check("full_ready",   ready,   1);
    check("full_length",  length,  8);
    check("full_overrun", overrun, 0);
    check_line("full_data");
    send_byte(8'h49, 1'b1);
    check("ovr_overrun", overrun, 1);
    check("ovr_length",  length,  8);
    addr = 3'd7;
    #1;
    check("ovr_frozen_data", data, 8'h48);
    pulse_ack();
    check("ovr_ack_ready",   ready,   0);
    check("ovr_ack_length",  length,  0);
    check("ovr_ack_overrun", overrun, 1);

    // Ack while collecting is ignored
    send_byte(8'h51, 1'b1);
    pulse_ack();
    check("ack_collect_length", length, 1);
    send_byte(8'h0D, 1'b1);
    check("ack_collect_ready", ready, 1);
    exp_q.push_back(8'h51);
    check_line("ack_collect_data");

    // Reset during bit 4 of 'Z'
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(z[i]);
    rx = z[4];
    wait_cycles(TICKS / 2);
    rst_n = 1'b0;
    wait_cycles(3);
    check("midrst_length",  length,    0);
    check("midrst_ready",   ready,     0);
    check("midrst_overrun", overrun,   0);
    check("midrst_frameerr", frame_err, 0);
    rx = 1'b1;
    wait_cycles(10);
    rst_n = 1'b1;
    wait_cycles(100);
    check("midrst_idle_length", length, 0);
    send_byte(8'h5A, 1'b1);
    send_byte(8'h0D, 1'b1);
    check("z_ready",  ready,  1);
    check("z_length", length, 1);
    exp_q.push_back(8'h5A);
    check_line("z_data");
    check("final_fe", fe_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
